// File: rtl/read_cycle_pkg.sv
// read_cycle_pkg: definitions shared by the external-SRAM read and write
// sequencers. It holds the state encoding, the default bus width and the
// idle levels of the shared latch/count lines.
package read_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_OE   = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAPT = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Idle levels of the shared lines. The write sequencer uses them as well.
  localparam logic IDLE_LATCH  = 1'b0;
  localparam logic IDLE_COUNT  = 1'b1;
  localparam logic IDLE_STROBE = 1'b1;

  // A read may start or continue only while no write is requested.
  function automatic logic read_granted(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/read_cycle_wait_timer.sv
// read_cycle_wait_timer: loadable down-counter that times the nOE-low wait
// states. The terminal flag 'last' is high while the count is 1 or less, so
// the cycle in which it is seen is the final wait cycle.
module read_cycle_wait_timer #(
  parameter int WCNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_value,
  input  logic              dec,
  output logic              last
);

  localparam logic [WCNT_W-1:0] CNT_ZERO = WCNT_W'(0);
  localparam logic [WCNT_W-1:0] CNT_ONE  = WCNT_W'(1);

  logic [WCNT_W-1:0] cnt_r;

  // Load the wait count, count it down (saturating at zero), or hold it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_value;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r <= CNT_ONE);

endmodule

// File: rtl/read_cycle.sv
// read_cycle: read-direction sequencer for the external SRAM-style data path.
// Each word: latch the address, drop nOE and count, wait WAIT_STATES clocks,
// capture data_in, then raise nOE/count and pulse data_valid. Words repeat
// back-to-back while read stays requested and write is low.
// Optional feature macro: READ_HOLD_EN. It adds the data_ack input and the
// HOLD state, which keeps data_valid high until the consumer acknowledges.
module read_cycle
  import read_cycle_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int WAIT_STATES = 1,
  parameter int WCNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef READ_HOLD_EN
  input  logic                  data_ack,
`endif
  output logic                  latch,
  output logic                  count,
  output logic                  nOE,
  output logic                  reading,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
);

  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);
  localparam logic              HAS_WAIT  = (WAIT_STATES > 0);

  state_t                  state_r, state_s;
  logic                    latch_r, latch_s;
  logic                    count_r, count_s;
  logic                    noe_r, noe_s;
  logic                    reading_r, reading_s;
  logic [DATA_WIDTH-1:0]   data_out_r, data_out_s;
  logic                    data_valid_r, data_valid_s;
  logic                    tmr_load_s;
  logic                    tmr_dec_s;
  logic                    tmr_last_s;
  logic                    go_s;

  assign go_s = read_granted(read, write);

  read_cycle_wait_timer #(
    .WCNT_W(WCNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_value (WAIT_LOAD),
    .dec        (tmr_dec_s),
    .last       (tmr_last_s)
  );

  // Next-state and next-output logic. Every output is registered below.
  always_comb begin
    state_s      = state_r;
    latch_s      = latch_r;
    count_s      = count_r;
    noe_s        = noe_r;
    reading_s    = reading_r;
    data_out_s   = data_out_r;
    data_valid_s = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_dec_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          reading_s = 1'b1;
          state_s   = ST_ADDR;
        end else begin
          reading_s = 1'b0;
          state_s   = ST_IDLE;
        end
      end
      ST_ADDR: begin
        latch_s = 1'b1;
        state_s = ST_OE;
      end
      ST_OE: begin
        latch_s    = IDLE_LATCH;
        noe_s      = 1'b0;
        count_s    = 1'b0;
        tmr_load_s = 1'b1;
        if (HAS_WAIT) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_CAPT;
        end
      end
      ST_WAIT: begin
        tmr_dec_s = 1'b1;
        if (tmr_last_s) begin
          state_s = ST_CAPT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CAPT: begin
        data_out_s   = data_in;
        data_valid_s = 1'b1;
        noe_s        = IDLE_STROBE;
        count_s      = IDLE_COUNT;
`ifdef READ_HOLD_EN
        state_s = ST_HOLD;
`else
        if (go_s) begin
          state_s = ST_ADDR;
        end else begin
          reading_s = 1'b0;
          state_s   = ST_IDLE;
        end
`endif
      end
`ifdef READ_HOLD_EN
      ST_HOLD: begin
        if (data_ack) begin
          data_valid_s = 1'b0;
          if (go_s) begin
            state_s = ST_ADDR;
          end else begin
            reading_s = 1'b0;
            state_s   = ST_IDLE;
          end
        end else begin
          data_valid_s = 1'b1;
          state_s      = ST_HOLD;
        end
      end
`endif
      default: begin
        state_s   = ST_IDLE;
        latch_s   = IDLE_LATCH;
        count_s   = IDLE_COUNT;
        noe_s     = IDLE_STROBE;
        reading_s = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset returns the bus to its idle levels at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      latch_r      <= IDLE_LATCH;
      count_r      <= IDLE_COUNT;
      noe_r        <= IDLE_STROBE;
      reading_r    <= 1'b0;
      data_out_r   <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      latch_r      <= latch_s;
      count_r      <= count_s;
      noe_r        <= noe_s;
      reading_r    <= reading_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
    end
  end

  assign latch      = latch_r;
  assign count      = count_r;
  assign nOE        = noe_r;
  assign reading    = reading_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;

endmodule

// File: doc/read_cycle.md
Name: read_cycle

Overview:
- Sequencer for the read direction of the external SRAM-style data path.
- Latches the address, pulses the address counter and asserts output-enable (nOE). Waits a fixed number of clocks, then captures the data bus and presents the word with a one-cycle valid strobe.
- Repeats back-to-back (burst) while read stays requested.
- Sits beside the existing write sequencer; both share the latch and count lines under a read/write arbitration rule.

Parameters:
- DATA_WIDTH, 8, width of the external data bus and of data_out.
- WAIT_STATES, 1, extra clocks nOE is held low before sampling (0 to 15).
- WCNT_W, 4, width of the wait counter; must hold WAIT_STATES.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- read  in  1  read request, level-sensitive.
- write  in  1  write request; a read starts only when write==0.
- data_in  in  DATA_WIDTH  external data bus, sampled in CAPT.
- latch  out  1  address latch enable, high for one clock per word.
- count  out  1  address counter strobe, idles high; low then high advances the counter.
- nOE  out  1  active-low memory output enable.
- reading  out  1  high while a read word or burst is in progress.
- data_out  out  DATA_WIDTH  last captured word, held until the next capture.
- data_valid  out  1  one-clock pulse, aligned with a data_out update.

Behaviour:
- Reset (reset==0, async) forces:
  - state=IDLE, latch=0, count=1, nOE=1, reading=0, data_valid=0, data_out=0, wait counter=0.
  - Asserting reset mid-word drops nOE to 1 immediately; no partial capture and no data_valid.
- All other updates are registered on the rising edge of clk.
- data_valid defaults to 0 every cycle unless set in CAPT.
- IDLE:
  - if read==1 & write==0: reading<=1, go to ADDR.
  - else: reading<=0, stay in IDLE.
- ADDR: latch<=1, go to OE.
- OE:
  - latch<=0, nOE<=0, count<=0, wcnt<=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else go to CAPT.
- WAIT: wcnt<=wcnt-1; go to CAPT when wcnt==1. This gives exactly WAIT_STATES cycles in WAIT.
- CAPT:
  - data_out<=data_in, data_valid<=1, nOE<=1, count<=1.
  - If read==1 & write==0: go to ADDR (burst, reading stays 1).
  - Else: go to IDLE with reading<=0.
- Latency:
  - Each word takes 3+WAIT_STATES clocks, from the ADDR entry edge to the CAPT exit edge.
  - data_valid is high in the cycle after CAPT.
- Simultaneous read==1 & write==1: treated as no read. IDLE stays IDLE; in CAPT the burst ends.
- read dropping or write rising mid-word does not abort the word. It completes through CAPT; only the continue decision uses the inputs.
- The read and write inputs are not sampled in ADDR, OE or WAIT.
- count falls exactly once and rises exactly once per word. Address increment per word is guaranteed.
- nOE is never low in ADDR or IDLE, which gives bus turnaround versus the write sequencer's DE.

Optional Feature:
- Macro READ_HOLD_EN.
- Defined:
  - Adds input data_ack (1 bit) and new state HOLD, entered from CAPT instead of the continue decision.
  - In HOLD, data_valid stays 1 and data_out is stable until data_ack==1. Then data_valid<=0 and the IDLE/ADDR decision is taken.
  - data_ack==1 already in CAPT is ignored; HOLD lasts at least one cycle.
- Undefined: no data_ack port, no HOLD state; data_valid is a one-clock pulse as above.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ADDR, OE, WAIT, CAPT, HOLD; 3-bit);
  - the default DATA_WIDTH;
  - the idle output constants (latch=0, count=1, strobe-inactive=1) used by both the read and write sequencers.
- One natural sub-module: wait_timer. It is a loadable down-counter with a terminal flag, parameterised by WCNT_W.
- The FSM and capture register stay in read_cycle.

Test Plan:
- Reset: hold reset=0 with read=1 -> outputs latch=0, count=1, nOE=1, reading=0, data_valid=0, data_out=0.
- Single read, WAIT_STATES=1, data_in=8'hA5: one read=1 clock in IDLE -> latch high 1 clk, nOE low 2 clks, count low 2 clks, data_out=8'hA5 with data_valid 1 clk, reading back to 0.
- Burst: read held 3 words, data_in 8'h11/8'h22/8'h33 -> three data_valid pulses 4 clocks apart, 3 count rising edges, reading continuous, data_out sequence correct.
- Conflict: read=1 & write=1 in IDLE -> no latch, nOE stays 1. write rises mid-burst -> current word completes, then IDLE.
- WAIT_STATES=0 and 3: nOE low 1 and 4 clks respectively; data sampled on the CAPT edge only. Changing data_in one clock earlier or later must not alter data_out.
- Reset mid-word (in WAIT): nOE returns to 1 asynchronously, no data_valid. After release, a fresh read works normally. With READ_HOLD_EN: data_ack delayed 5 clks -> data_valid high 5+ clks, no new latch until ack.
